// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine input sequencer: request indices,
// FSM states and the fixed grant priority.
package vm_pkg;

  localparam int unsigned REQ_W     = 9;
  localparam int unsigned REQ_IDX_W = 4;

  localparam int unsigned REQ_M100   = 0;
  localparam int unsigned REQ_M200   = 1;
  localparam int unsigned REQ_M500   = 2;
  localparam int unsigned REQ_M1000  = 3;
  localparam int unsigned REQ_B300   = 4;
  localparam int unsigned REQ_B500   = 5;
  localparam int unsigned REQ_B700   = 6;
  localparam int unsigned REQ_B900   = 7;
  localparam int unsigned REQ_REFUND = 8;

  localparam logic [REQ_W-1:0] BUY_MASK = 9'h0F0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Highest priority first
  localparam logic [REQ_IDX_W-1:0] PRIO_ORDER [REQ_W] = '{
    REQ_IDX_W'(REQ_REFUND),
    REQ_IDX_W'(REQ_M100), REQ_IDX_W'(REQ_M200), REQ_IDX_W'(REQ_M500), REQ_IDX_W'(REQ_M1000),
    REQ_IDX_W'(REQ_B300), REQ_IDX_W'(REQ_B500), REQ_IDX_W'(REQ_B700), REQ_IDX_W'(REQ_B900)
  };

  // One-hot grant of the highest-priority set request (zero if none)
  function automatic logic [REQ_W-1:0] pick_grant(input logic [REQ_W-1:0] req);
    logic [REQ_W-1:0] grant;
    logic             found;
    grant = '0;
    found = 1'b0;
    for (logic [REQ_IDX_W-1:0] i = '0; i < REQ_IDX_W'(REQ_W); i++) begin
      if (!found && req[PRIO_ORDER[i]]) begin
        grant[PRIO_ORDER[i]] = 1'b1;
        found                = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/vm_input_sequencer_sync_edge.sv
// One raw input line: multi-flop synchroniser followed by rising-edge detect.
module vm_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic press_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // prev_q resets low, so a line held through reset release yields one press
  assign press_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/vm_input_sequencer.sv
// Latches synchronised button/coin presses and feeds them to the vending machine
// as single-cycle one-hot pulses, in fixed priority, with a hold-off gap.
module vm_input_sequencer
  import vm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned GAP_W       = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       btn_moneyin,
  input  logic [3:0]       btn_buy,
  input  logic             btn_refund,
  output logic [3:0]       moneyin,
  output logic [3:0]       buy,
  output logic             refund,
  output logic [REQ_W-1:0] pending,
  output logic             busy,
  output logic             drop_pulse
);

  logic [REQ_W-1:0] raw_c;
  logic [REQ_W-1:0] press_c;
  logic [REQ_W-1:0] grant_c;
  logic [REQ_W-1:0] clr_c;
  logic [REQ_W-1:0] pending_d;
  logic             drop_c;
  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  assign raw_c = {btn_refund, btn_buy, btn_moneyin};

  for (genvar g = 0; g < REQ_W; g++) begin : g_sync
    vm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (raw_c[g]),
      .press_c (press_c[g])
    );
  end

  // Next-state, grant and gap counter
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    grant_c = '0;
    case (state_q)
      IDLE: begin
        if (|pending) begin
          grant_c = pick_grant(pending);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (GAP_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
          gap_d   = GAP_W'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // A refund grant also flushes queued buys; a press in the same cycle survives
  always_comb begin
    clr_c     = grant_c | (grant_c[REQ_REFUND] ? BUY_MASK : '0);
    pending_d = (pending & ~clr_c) | press_c;
    drop_c    = |(press_c & pending & ~clr_c);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      pending    <= '0;
      moneyin    <= '0;
      buy        <= '0;
      refund     <= 1'b0;
      busy       <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      pending    <= pending_d;
      moneyin    <= grant_c[REQ_M1000:REQ_M100];
      buy        <= grant_c[REQ_B900:REQ_B300];
      refund     <= grant_c[REQ_REFUND];
      busy       <= (state_d != IDLE);
      drop_pulse <= drop_c;
    end
  end

endmodule
